rst_sequencer: RTL
==================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 3, meaning number of reset outputs; legal range 2..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning clk cycles all outputs stay asserted before the first release; minimum 1.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, meaning clk cycles between consecutive releases; minimum 1.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port i_rst_async  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_req  input  1  synchronous software reset request, sampled at the rising edge of clk.
REQ-007 SHALL have port o_rst  output  NUM_OUT  active-high domain resets, each driven directly from a flop.
REQ-008 SHALL have port o_busy  output  1  high while a sequence is in progress.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse marking sequence completion.

Function
REQ-010 SHALL implement the states HOLD, REL and IDLE.
REQ-011 HOLD SHALL keep every o_rst bit at 1 and count HOLD_CYCLES rising edges.
- On the HOLD_CYCLES-th edge, o_rst[0] SHALL go to 0.
- On that same edge, the state SHALL move to REL with index 1.
REQ-012 REL SHALL count GAP_CYCLES edges, then clear o_rst[index] on the GAP_CYCLES-th edge.
- Releases SHALL occur in strictly ascending index order, one bit per release.
REQ-013 The final release (index NUM_OUT-1) SHALL drive o_busy to 0 and o_done to 1 on the same edge, then move to IDLE.
- o_done SHALL return to 0 on the next edge.
REQ-014 In IDLE, i_req=1 at an edge SHALL set all o_rst bits and o_busy to 1 on that edge and enter HOLD with counter 0.
REQ-015 A request SHALL be accepted only when o_busy is 0 at the sampling edge.
- Requests while busy, including on the final-release edge, SHALL be dropped, not queued.
REQ-016 i_req held high continuously SHALL restart a sequence on the first edge after each completion.
REQ-017 An o_rst bit, once released, SHALL stay 0 until the next reset or accepted request.
- No o_rst bit SHALL glitch.
REQ-018 Counters SHALL be $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits wide.
- Counters SHALL clear on every state change.

Reset
REQ-019 i_rst_async=1 SHALL immediately and asynchronously force the following, regardless of state, including mid-sequence:
- o_rst all 1s, o_busy=1, o_done=0;
- state HOLD, counter 0, index 0.
REQ-020 After i_rst_async deasserts, the first clk rising edge SHALL count as HOLD edge 1.
REQ-021 i_rst_async SHALL be the only asynchronous input.
- Integration is responsible for deassertion timing of i_rst_async.

Configuration
REQ-022 With macro RST_SEQ_REQ_CNT_EN defined, the module SHALL add output o_req_cnt, 8 bits wide.
- o_req_cnt SHALL increment on each accepted request and saturate at 255.
- o_req_cnt SHALL be cleared only by i_rst_async.
REQ-023 Without RST_SEQ_REQ_CNT_EN, neither the o_req_cnt port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification (defaults NUM_OUT=3, HOLD_CYCLES=16, GAP_CYCLES=4)
REQ-024 Power-on: release i_rst_async before edge 1 -> o_rst goes 3'b110 at edge 16, 3'b100 at edge 20, 3'b000 at edge 24; o_done=1 only in the cycle after edge 24; o_busy=0 from edge 24.
REQ-025 Idle request: single-cycle i_req sampled at edge T -> o_rst=3'b111 and o_busy=1 after T; releases at T+16, T+20, T+24.
REQ-026 Request while busy: i_req pulses at edges T+5 and T+24 of a running sequence -> both ignored; timing identical to REQ-025; o_req_cnt (if enabled) increments by 1 only.
REQ-027 Reset mid-sequence: assert i_rst_async 2 cycles after o_rst[1] releases -> o_rst=3'b111 immediately; after deassertion, the full 16/20/24 timing restarts.
REQ-028 Held request: i_req=1 continuously from edge 30 -> back-to-back sequences, each re-entered on the edge after o_done; with macro defined, o_req_cnt saturates at 255 after 256+ sequences.
REQ-029 Parameter sweep: NUM_OUT=2, HOLD_CYCLES=1, GAP_CYCLES=1 -> releases at edges 1 and 2; o_done pulse after edge 2.

Source files
------------

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Staged reset release sequencer. On power-on (i_rst_async) or on an accepted
// software request (i_req) every domain reset is asserted, held for
// HOLD_CYCLES clocks, then released one bit at a time in ascending index
// order with GAP_CYCLES clocks between releases. The final release raises a
// one-cycle o_done pulse and drops o_busy.
//
// Parameters
//   NUM_OUT     : number of domain reset outputs (2..8)
//   HOLD_CYCLES : clocks all outputs stay asserted before the first release (>= 1)
//   GAP_CYCLES  : clocks between consecutive releases (>= 1)
//
// Ports
//   clk         : in  single clock for all logic
//   i_rst_async : in  asynchronous active-high reset (the only async input)
//   i_req       : in  synchronous software reset request
//   o_rst       : out [NUM_OUT-1:0] active-high domain resets, straight from flops
//   o_busy      : out high while a sequence is in progress
//   o_done      : out one-cycle pulse on sequence completion
//   o_req_cnt   : out [7:0] saturating count of accepted requests
//                 (present only when RST_SEQ_REQ_CNT_EN is defined)
//
// Optional feature macro: RST_SEQ_REQ_CNT_EN
// -----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int unsigned NUM_OUT     = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               i_rst_async,
    input  logic               i_req,
    output logic [NUM_OUT-1:0] o_rst,
    output logic               o_busy,
`ifdef RST_SEQ_REQ_CNT_EN
    output logic               o_done,
    output logic [7:0]         o_req_cnt
`else
    output logic               o_done
`endif
);

    // -------------------------------------------------------------------------
    // Derived widths and constants
    // -------------------------------------------------------------------------
    localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam int unsigned IdxW      = $clog2(NUM_OUT);

    // Counter values seen on the edge that completes a HOLD / GAP interval.
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_OUT - 1);
    localparam logic [IdxW-1:0] IdxFirst = IdxW'(1);

    // State encoding
    localparam logic [1:0] StHold = 2'd0;
    localparam logic [1:0] StRel  = 2'd1;
    localparam logic [1:0] StIdle = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // A request is only honoured from IDLE; busy is low exactly in IDLE, so
    // requests during HOLD/REL (including the final-release edge) are dropped.
    logic req_accept;
    assign req_accept = (state_q == StIdle) && i_req;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    // First release happens on the last HOLD edge itself.
                    rst_d[0] = 1'b0;
                    state_d  = StRel;
                    idx_d    = IdxFirst;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StRel: begin
                if (cnt_q == GapLast) begin
                    rst_d[idx_q] = 1'b0;
                    cnt_d        = '0;
                    if (idx_q == IdxLast) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StIdle: begin
                if (req_accept) begin
                    rst_d   = '1;
                    busy_d  = 1'b1;
                    state_d = StHold;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            default: begin
                // Unreachable encoding: recover by restarting a full sequence.
                rst_d   = '1;
                busy_d  = 1'b1;
                state_d = StHold;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from flops so downstream resets never glitch.
    assign o_rst  = rst_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

`ifdef RST_SEQ_REQ_CNT_EN
    // -------------------------------------------------------------------------
    // Accepted-request counter, saturating; only the async reset clears it.
    // -------------------------------------------------------------------------
    logic [7:0] req_cnt_q, req_cnt_d;

    always_comb begin
        req_cnt_d = req_cnt_q;
        if (req_accept && (req_cnt_q != 8'hff)) begin
            req_cnt_d = req_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            req_cnt_q <= '0;
        end else begin
            req_cnt_q <= req_cnt_d;
        end
    end

    assign o_req_cnt = req_cnt_q;
`endif

endmodule
